// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// Combinational grant selection: sticky owner until the burst fills, then round-robin.
module rr_pick
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       owner,
    input  logic       owner_valid,
    input  logic       burst_full,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // one-hot grant from the request pattern and arbiter history
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (owner_valid && !burst_full) begin
                    grant = (owner == M1) ? 2'b10 : 2'b01;
                end else begin
                    grant = (last_grant == M1) ? 2'b01 : 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of a single-port data memory with bounded bursts.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    input  logic [31:0]   mem_rd
);

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BURST_MAX_C = CW'(BURST_MAX);

    arb_state_e    state_r, state_nxt_s;
    logic          last_grant_r, last_grant_nxt_s;
    logic [CW-1:0] burst_cnt_r, burst_cnt_nxt_s;
    logic [1:0]    pick_s, gnt_s;
    logic          m0_rvalid_r, m1_rvalid_r;
    logic [31:0]   m0_rdata_r, m1_rdata_r;

    rr_pick u_pick (
        .req         ({m1_req, m0_req}),
        .owner       (state_r == SERVE1),
        .owner_valid (state_r != IDLE),
        .burst_full  (burst_cnt_r == BURST_MAX_C),
        .last_grant  (last_grant_r),
        .grant       (pick_s)
    );

    // reset cancels any access in the same cycle
    assign gnt_s  = reset ? 2'b00 : pick_s;
    assign m0_gnt = gnt_s[0];
    assign m1_gnt = gnt_s[1];

    // route the granted master onto the memory port
    always_comb begin
        mem_addr = {AW{1'b0}};
        mem_wd   = 32'h0000_0000;
        mem_we   = 1'b0;
        if (gnt_s[0]) begin
            mem_addr = m0_addr;
            mem_wd   = m0_wdata;
            mem_we   = m0_we;
        end else if (gnt_s[1]) begin
            mem_addr = m1_addr;
            mem_wd   = m1_wdata;
            mem_we   = m1_we;
        end else begin
            mem_we   = 1'b0;
        end
    end

    // next arbiter state, owner history and burst length
    always_comb begin
        state_nxt_s      = IDLE;
        last_grant_nxt_s = last_grant_r;
        burst_cnt_nxt_s  = {CW{1'b0}};
        if (gnt_s[0]) begin
            state_nxt_s      = SERVE0;
            last_grant_nxt_s = M0;
            burst_cnt_nxt_s  = (state_r != SERVE0) ? CW'(1) :
                               (burst_cnt_r == BURST_MAX_C) ? BURST_MAX_C : burst_cnt_r + CW'(1);
        end else if (gnt_s[1]) begin
            state_nxt_s      = SERVE1;
            last_grant_nxt_s = M1;
            burst_cnt_nxt_s  = (state_r != SERVE1) ? CW'(1) :
                               (burst_cnt_r == BURST_MAX_C) ? BURST_MAX_C : burst_cnt_r + CW'(1);
        end else begin
            state_nxt_s      = IDLE;
            burst_cnt_nxt_s  = {CW{1'b0}};
        end
    end

    // arbiter state registers; master 0 wins the first contention after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= M1;
            burst_cnt_r  <= {CW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            burst_cnt_r  <= burst_cnt_nxt_s;
        end
    end

    // read-return path: capture memory data at the end of a read grant
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rvalid_r <= 1'b0;
            m1_rvalid_r <= 1'b0;
            m0_rdata_r  <= 32'h0000_0000;
            m1_rdata_r  <= 32'h0000_0000;
        end else begin
            m0_rvalid_r <= gnt_s[0] & ~m0_we;
            m1_rvalid_r <= gnt_s[1] & ~m1_we;
            if (gnt_s[0] && !m0_we) begin
                m0_rdata_r <= mem_rd;
            end
            if (gnt_s[1] && !m1_we) begin
                m1_rdata_r <= mem_rd;
            end
        end
    end

    assign m0_rvalid = m0_rvalid_r;
    assign m1_rvalid = m1_rvalid_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_rdata  = m1_rdata_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed vector bench for dm_arbiter with a small behavioural data memory.
module tb_dm_arbiter;

    localparam logic [31:0] A1 = 32'hA000_0001;
    localparam logic [31:0] A2 = 32'hA000_0002;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        tb_init;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;
    logic [31:0] mem [64];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.BURST_MAX(4), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    // word-addressed memory, preloaded with A000_00<index>
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_addr[7:2]];

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0,
                                input logic r1, w1, input logic [31:0] a1, d1,
                                input logic g0, g1, rv0, input logic [31:0] rd0,
                                input logic rv1, input logic [31:0] rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                         input logic r1, w1, input logic [31:0] a1, d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    initial begin
        logic [31:0] e_addr, e_wd;
        logic        e_we;

        // both masters reading: 4-long bursts alternate
        tbl[0] = mk(1'b1,1'b0,32'h04,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0);
        for (int i = 1; i < 4; i++)
            tbl[i] = mk(1'b1,1'b0,32'h04,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b1,1'b0, 1'b1,A1, 1'b0,32'h0);
        tbl[4] = mk(1'b1,1'b0,32'h04,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b0,1'b1, 1'b1,A1, 1'b0,32'h0);
        for (int i = 5; i < 8; i++)
            tbl[i] = mk(1'b1,1'b0,32'h04,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b0,1'b1, 1'b0,A1, 1'b1,A2);
        tbl[8] = mk(1'b1,1'b0,32'h04,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b1,1'b0, 1'b0,A1, 1'b1,A2);
        // m0 writes, m1 reads it back
        tbl[9]  = mk(1'b1,1'b1,32'h10,DB,   1'b0,1'b0,32'h0,32'h0,  1'b1,1'b0, 1'b1,A1, 1'b0,A2);
        tbl[10] = mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h10,32'h0, 1'b0,1'b1, 1'b0,A1, 1'b0,A2);
        tbl[11] = mk(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0, 1'b0,A1, 1'b1,DB);
        tbl[12] = mk(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0, 1'b0,A1, 1'b0,DB);
        // m1 alone for 10 cycles: no burst limit
        tbl[13] = mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b0,1'b1, 1'b0,A1, 1'b0,DB);
        for (int i = 14; i < 23; i++)
            tbl[i] = mk(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b0,1'b1, 1'b0,A1, 1'b1,A2);
        // saturated burst hands over; m0 drops req; new m1 burst holds
        tbl[23] = mk(1'b1,1'b0,32'h04,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b1,1'b0, 1'b0,A1, 1'b1,A2);
        tbl[24] = mk(1'b0,1'b0,32'h0,32'h0,  1'b1,1'b0,32'h08,32'h0, 1'b0,1'b1, 1'b1,A1, 1'b0,A2);
        tbl[25] = mk(1'b1,1'b0,32'h04,32'h0, 1'b1,1'b0,32'h08,32'h0, 1'b0,1'b1, 1'b0,A1, 1'b1,A2);

        reset = 1'b1;
        tb_init = 1'b1;
        drive(1'b1,1'b1,32'h04,32'h1234_5678, 1'b1,1'b1,32'h08,32'h8765_4321);
        @(negedge clk);
        #1;
        chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
        chk("rst_we",   {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        tb_init = 1'b0;
        reset = 1'b0;
        drive(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0);
        #1;
        chk("rst_rv0", {31'd0, m0_rvalid}, 32'd0);
        chk("rst_rv1", {31'd0, m1_rvalid}, 32'd0);
        chk("rst_rd0", m0_rdata, 32'd0);
        chk("rst_rd1", m1_rdata, 32'd0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            e_addr = tbl[i].g0 ? tbl[i].a0 : (tbl[i].g1 ? tbl[i].a1 : 32'h0);
            e_wd   = tbl[i].g0 ? tbl[i].d0 : (tbl[i].g1 ? tbl[i].d1 : 32'h0);
            e_we   = tbl[i].g0 ? tbl[i].w0 : (tbl[i].g1 ? tbl[i].w1 : 1'b0);
            #1;
            chk($sformatf("v%0d_gnt", i), {30'd0, m1_gnt, m0_gnt}, {30'd0, tbl[i].g1, tbl[i].g0});
            chk($sformatf("v%0d_addr", i), mem_addr, e_addr);
            chk($sformatf("v%0d_wd", i), mem_wd, e_wd);
            chk($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, e_we});
            chk($sformatf("v%0d_rv", i), {30'd0, m1_rvalid, m0_rvalid}, {30'd0, tbl[i].rv1, tbl[i].rv0});
            chk($sformatf("v%0d_rd0", i), m0_rdata, tbl[i].rd0);
            chk($sformatf("v%0d_rd1", i), m1_rdata, tbl[i].rd1);
        end

        // reset lands on an m0 write grant to 0x20: write must be dropped
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1,1'b1,32'h20,32'h5555_AAAA, 1'b1,1'b0,32'h08,32'h0);
        #1;
        chk("wrst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("wrst_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0);
        #1;
        chk("wrst_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("wrst_rd0", m0_rdata, 32'd0);
        chk("wrst_rd1", m1_rdata, 32'd0);
        @(negedge clk);
        drive(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0);
        #1;
        chk("post_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        chk("post_addr", mem_addr, 32'h20);
        @(negedge clk);
        drive(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0);
        #1;
        chk("post_rv0", {31'd0, m0_rvalid}, 32'd1);
        chk("post_rd0", m0_rdata, 32'hA000_0008);
        chk("post_rv1", {31'd0, m1_rvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum consecutive grants to one master while the other master is requesting.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 requests one word access this cycle.
- m0_we  input  1  master 0 write (1) or read (0).
- m0_addr  input  AW  master 0 byte address.
- m0_wdata  input  32  master 0 write data.
- m0_gnt  output  1  master 0 access performed this cycle.
- m0_rvalid  output  1  master 0 read data valid.
- m0_rdata  output  32  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same directions, widths and meanings for master 1.
- mem_addr  output  AW  address to the single-port data memory.
- mem_wd  output  32  write data to memory.
- mem_we  output  1  memory write enable.
- mem_rd  input  32  combinational read data from memory.

Function
REQ-004 One memory access per cycle; a master's access is performed in the cycle its gnt is high.
REQ-005 gnt SHALL be combinational from req and registered arbiter state; at most one gnt high per cycle; gnt never high without the matching req.
REQ-006 Granted master's addr/wdata/we SHALL drive mem_addr/mem_wd/mem_we; with no grant, mem_we = 0 and mem_addr/mem_wd = 0.
REQ-007 Write: memory commits on the clock edge ending the grant cycle; no rvalid for writes.
REQ-008 Read: mem_rd captured at the end of the grant cycle; the master's rvalid high for exactly the next cycle with rdata = captured value; rdata holds its value afterwards.
REQ-009 FSM states IDLE, SERVE0, SERVE1; state after each edge = SERVE<k> if master k was granted that cycle, else IDLE.
REQ-010 Only one master requesting: it is granted regardless of state or burst count.
REQ-011 Both requesting, state SERVE<k>, burst_cnt < BURST_MAX: grant master k.
REQ-012 Both requesting otherwise (IDLE, or burst_cnt = BURST_MAX): grant the master not recorded in last_grant.
REQ-013 last_grant register updated to the granted master on every grant; unchanged in idle cycles.
REQ-014 burst_cnt: set to 1 on a grant to a master different from the previous cycle's grant or after IDLE; incremented (saturating at BURST_MAX) on a repeat grant; cleared to 0 in idle cycles.
REQ-015 A master dropping req mid-burst loses ownership immediately; no grant is held without req.
REQ-016 Same-cycle read by one master and pending rvalid to the other is legal; both rvalids may not be high together (guaranteed by REQ-005).

Reset
REQ-017 While reset is high: m0_gnt = m1_gnt = 0, mem_we = 0, regardless of req.
REQ-018 After reset: state IDLE, last_grant = 1 (master 0 wins first contention), burst_cnt = 0, m0_rvalid = m1_rvalid = 0, m0_rdata = m1_rdata = 0.
REQ-019 Reset asserted in a grant cycle: the access is cancelled (no write, no rvalid).

Structure
REQ-020 Package dm_arb_pkg SHALL hold the state enum (IDLE, SERVE0, SERVE1), master-ID constants M0 = 0, M1 = 1, and the BURST_MAX default.
REQ-021 One sub-module rr_pick: inputs req[1:0], owner, owner_valid, burst_full, last_grant; output one-hot grant[1:0]; purely combinational.

Verification
REQ-022 After reset, both req in cycle 1 -> m0_gnt = 1, m1_gnt = 0; mem_addr = m0_addr.
REQ-023 Both req continuously, BURST_MAX = 4 -> grant pattern 0,0,0,0,1,1,1,1,0 ...
REQ-024 m0 writes 0xDEADBEEF to 0x10, then m1 reads 0x10 -> m1_rvalid one cycle after m1_gnt, m1_rdata = 0xDEADBEEF, m0_rvalid stays 0.
REQ-025 m1 alone requests 10 cycles -> m1_gnt high all 10 cycles, no burst limit applied.
REQ-026 Reset raised during an m0 write grant to 0x20 -> mem_we = 0, later read of 0x20 returns its prior value, outputs at REQ-018 values.
